// File: rtl/turn_move_controller.sv
// Turn move controller: drops the current player's piece into the chosen (or timed-out,
// pseudo-random) column, maintains the board image and hands the turn over.
module turn_move_controller #(
  parameter int unsigned COLS = 7,
  parameter int unsigned ROWS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_confirm,
  input  logic [2:0]               col_sel,
  input  logic                     tiempo,
  input  logic [7:0]               posicion_ra,
  input  logic                     gano,
  output logic                     guardado,
  output logic                     turno,
  output logic [2*ROWS*COLS-1:0]   tablero,
  output logic [2:0]               ultima_fila,
  output logic [2:0]               ultima_col,
  output logic                     invalida,
  output logic                     tablero_lleno,
  output logic                     busy
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, FIND, PLACE, DONE} state_t;
  typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

  state_t          state_q, state_d;
  board_t          board_q, board_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   att_q, att_d;
  logic            src_auto_q, src_auto_d;
  logic            guardado_d, invalida_d, turno_d, lleno_d, busy_d;
  logic [2:0]      ultima_fila_d, ultima_col_d;

  logic [COLS-1:0] top_occ;
  logic            accept_c;
  logic            col_ok_c;
  logic            col_full_c;
  logic            cell_empty_c;
  logic            last_try_c;
  logic [CW-1:0]   auto_col_c;
  logic [CW-1:0]   next_col_c;

  // Occupancy of the top row; a column is full exactly when its top cell is taken.
  for (genvar i = 0; i < COLS; i++) begin : g_top
    assign top_occ[i] = |board_q[ROWS-1][i];
  end

  assign accept_c     = !gano && !tablero_lleno;
  assign col_ok_c     = 32'(col_sel) < COLS;
  assign col_full_c   = top_occ[c_q];
  assign cell_empty_c = (board_q[r_q][c_q] == 2'b00);
  assign last_try_c   = (att_q == CW'(COLS - 1));
  assign auto_col_c   = CW'(posicion_ra % 8'(COLS));
  assign next_col_c   = (c_q == CW'(COLS - 1)) ? '0 : c_q + 1'b1;

  assign tablero = board_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (btn_confirm) begin
            if (col_ok_c) state_d = CHECK;
          end else if (tiempo) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (!col_full_c)     state_d = FIND;
        else if (!src_auto_q) state_d = IDLE;
        else if (last_try_c)  state_d = IDLE;
      end
      FIND:    if (cell_empty_c) state_d = PLACE;
      PLACE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    board_d       = board_q;
    c_d           = c_q;
    r_d           = r_q;
    att_d         = att_q;
    src_auto_d    = src_auto_q;
    guardado_d    = 1'b0;
    invalida_d    = 1'b0;
    turno_d       = turno;
    lleno_d       = tablero_lleno;
    ultima_fila_d = ultima_fila;
    ultima_col_d  = ultima_col;
    busy_d        = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (btn_confirm) begin
            if (col_ok_c) begin
              c_d        = CW'(col_sel);
              src_auto_d = 1'b0;
              att_d      = '0;
            end else begin
              invalida_d = 1'b1;
            end
          end else if (tiempo) begin
            c_d        = auto_col_c;
            src_auto_d = 1'b1;
            att_d      = '0;
          end
        end
      end
      CHECK: begin
        if (!col_full_c) begin
          r_d = '0;
        end else if (!src_auto_q) begin
          invalida_d = 1'b1;
        end else if (last_try_c) begin
          lleno_d = 1'b1;
        end else begin
          c_d   = next_col_c;
          att_d = att_q + 1'b1;
        end
      end
      FIND: begin
        if (!cell_empty_c) r_d = r_q + 1'b1;
      end
      PLACE: begin
        board_d[r_q][c_q] = turno ? 2'b10 : 2'b01;
        ultima_fila_d     = 3'(r_q);
        ultima_col_d      = 3'(c_q);
        guardado_d        = 1'b1;
      end
      DONE: begin
        turno_d = ~turno;
        lleno_d = &top_occ;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q       <= '0;
      c_q           <= '0;
      r_q           <= '0;
      att_q         <= '0;
      src_auto_q    <= 1'b0;
      guardado      <= 1'b0;
      invalida      <= 1'b0;
      turno         <= 1'b0;
      tablero_lleno <= 1'b0;
      ultima_fila   <= '0;
      ultima_col    <= '0;
      busy          <= 1'b0;
    end else begin
      board_q       <= board_d;
      c_q           <= c_d;
      r_q           <= r_d;
      att_q         <= att_d;
      src_auto_q    <= src_auto_d;
      guardado      <= guardado_d;
      invalida      <= invalida_d;
      turno         <= turno_d;
      tablero_lleno <= lleno_d;
      ultima_fila   <= ultima_fila_d;
      ultima_col    <= ultima_col_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_turn_move_controller.sv
// Directed bench for turn_move_controller: board model plus a scoreboard of expected
// commits (position, value, latency) checked whenever guardado pulses.
module tb_turn_move_controller;

  localparam int unsigned COLS = 7;
  localparam int unsigned ROWS = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   btn_confirm;
  logic [2:0]             col_sel;
  logic                   tiempo;
  logic [7:0]             posicion_ra;
  logic                   gano;
  logic                   guardado;
  logic                   turno;
  logic [2*ROWS*COLS-1:0] tablero;
  logic [2:0]             ultima_fila;
  logic [2:0]             ultima_col;
  logic                   invalida;
  logic                   tablero_lleno;
  logic                   busy;

  turn_move_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .btn_confirm(btn_confirm), .col_sel(col_sel),
    .tiempo(tiempo), .posicion_ra(posicion_ra), .gano(gano),
    .guardado(guardado), .turno(turno), .tablero(tablero),
    .ultima_fila(ultima_fila), .ultima_col(ultima_col), .invalida(invalida),
    .tablero_lleno(tablero_lleno), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         row;
    int         col;
    logic [1:0] val;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mdl [ROWS][COLS];
  logic       mdl_turn;
  logic       mdl_lleno;
  int         ecnt = 0;
  int         checks = 0;
  int         failures = 0;
  int         g_cnt = 0;
  int         inv_cnt = 0;
  int         exp_g = 0;
  int         exp_inv = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every commit must match the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      if (invalida) inv_cnt++;
      if (guardado) begin
        g_cnt++;
        check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ultima_fila", ultima_fila, 128'(e.row));
          check("ultima_col", ultima_col, 128'(e.col));
          check("cell_val", tablero[2*(e.row*COLS+e.col) +: 2], e.val);
          check("latency", 128'(ecnt), 128'(e.due));
        end
      end
    end
  end

  function automatic int height(input int c);
    int h = 0;
    for (int r = 0; r < ROWS; r++) if (mdl[r][c] != 2'b00) h++;
    return h;
  endfunction

  function automatic logic [2*ROWS*COLS-1:0] flat();
    logic [2*ROWS*COLS-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[2*(r*COLS+c) +: 2] = mdl[r][c];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 2'b00;
    mdl_turn  = 1'b0;
    mdl_lleno = 1'b0;
    sb.delete();
  endtask

  // Called at the negedge before the sampling edge; 'extra' is the number of skipped columns
  task automatic commit_model(input int c, input int extra);
    int h;
    logic full;
    h = height(c);
    sb.push_back('{h, c, (mdl_turn ? 2'b10 : 2'b01), ecnt + 4 + h + extra});
    mdl[h][c] = mdl_turn ? 2'b10 : 2'b01;
    mdl_turn  = ~mdl_turn;
    exp_g++;
    full = 1'b1;
    for (int i = 0; i < COLS; i++) if (mdl[ROWS-1][i] == 2'b00) full = 1'b0;
    mdl_lleno = full;
  endtask

  task automatic model_manual(input int c);
    if (mdl_lleno) return;
    if (c >= COLS || height(c) == ROWS) exp_inv++;
    else commit_model(c, 0);
  endtask

  task automatic model_auto(input int p);
    int c;
    int j;
    if (mdl_lleno) return;
    c = p % COLS;
    j = 0;
    while (j < COLS && height(c) == ROWS) begin
      c = (c + 1) % COLS;
      j++;
    end
    if (j == COLS) mdl_lleno = 1'b1;
    else commit_model(c, j);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_tablero"}, tablero, flat());
    check({tag, "_turno"}, turno, mdl_turn);
    check({tag, "_lleno"}, tablero_lleno, mdl_lleno);
    check({tag, "_gcnt"}, 128'(g_cnt), 128'(exp_g));
    check({tag, "_invcnt"}, 128'(inv_cnt), 128'(exp_inv));
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    check({tag, "_pulses_low"}, {guardado, invalida}, 2'b00);
  endtask

  task automatic manual(input int c, input string tag);
    @(negedge clk);
    model_manual(c);
    btn_confirm = 1'b1;
    col_sel     = 3'(c);
    @(negedge clk);
    btn_confirm = 1'b0;
    wait_idle();
    check_state(tag);
  endtask

  task automatic auto_move(input int p, input string tag);
    @(negedge clk);
    model_auto(p);
    tiempo      = 1'b1;
    posicion_ra = 8'(p);
    @(negedge clk);
    tiempo = 1'b0;
    wait_idle();
    check_state(tag);
  endtask

  initial begin
    rst = 1'b0; btn_confirm = 1'b0; col_sel = '0; tiempo = 1'b0;
    posicion_ra = '0; gano = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", {guardado, invalida, turno, ultima_fila, ultima_col, tablero_lleno, busy}, '0);
    check("rst_tablero", tablero, '0);
    rst = 1'b1;

    // First move and stacking on column 3 (k = 0..3)
    manual(3, "m_col3_a");
    check("turno_after_first", turno, 1'b1);
    manual(3, "m_col3_b");
    manual(3, "m_col3_c");
    manual(3, "m_col3_d");

    // Fill column 5, then reject a move into it and an out-of-range column
    for (int i = 0; i < ROWS; i++) manual(5, "fill5");
    manual(5, "rej_full5");
    manual(7, "rej_col7");

    // Columns 6 and 0 full; timeout at 13 wraps past both into column 1
    for (int i = 0; i < ROWS; i++) manual(6, "fill6");
    for (int i = 0; i < ROWS; i++) manual(0, "fill0");
    auto_move(13, "auto_wrap");

    // Simultaneous confirm/timeout: manual wins; a timeout while busy is dropped
    @(negedge clk);
    model_manual(2);
    btn_confirm = 1'b1; col_sel = 3'd2; tiempo = 1'b1; posicion_ra = 8'd4;
    @(negedge clk);
    btn_confirm = 1'b0; tiempo = 1'b0;
    @(negedge clk);
    check("busy_during_move", busy, 1'b1);
    tiempo = 1'b1; posicion_ra = 8'd4;
    @(negedge clk);
    tiempo = 1'b0;
    wait_idle();
    check_state("simul");

    // gano blocks both request kinds
    @(negedge clk);
    gano = 1'b1; btn_confirm = 1'b1; col_sel = 3'd4; tiempo = 1'b1; posicion_ra = 8'd2;
    @(negedge clk);
    btn_confirm = 1'b0; tiempo = 1'b0;
    check("gano_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_state("gano");
    gano = 1'b0;

    // Fill the whole board; afterwards a timeout is ignored
    for (int c = 0; c < COLS; c++)
      while (height(c) < ROWS) manual(c, "fill_all");
    check("board_full_flag", tablero_lleno, 1'b1);
    auto_move(9, "full_tiempo");

    // Reset in the middle of FIND
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    manual(0, "pre_rst_a");
    manual(0, "pre_rst_b");
    @(negedge clk);
    btn_confirm = 1'b1; col_sel = 3'd0;
    @(negedge clk);
    btn_confirm = 1'b0;
    @(negedge clk);
    check("busy_before_rst", busy, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_tablero", tablero, '0);
    check("midrst_outputs", {guardado, invalida, turno, ultima_fila, ultima_col, tablero_lleno, busy}, '0);
    @(negedge clk);
    rst = 1'b1;
    manual(4, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_move_controller.md
Name: turn_move_controller

Overview:
- Consumes the turn timer's timeout pulse (`tiempo`) and random position (`posicion_ra`), plus the player's confirmed column choice.
- Drops a piece into the lowest empty cell of the chosen column, or of a pseudo-random column on timeout.
- Updates the board image read by the VGA renderer and win checker.
- Pulses `guardado` back to the timer to restart the 15 s countdown, then hands the turn to the other player.

Parameters:
- COLS, 7, board columns (2..8).
- ROWS, 6, board rows (2..8).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btn_confirm  in  1  one-cycle pulse, debounced; player confirms `col_sel`.
- col_sel  in  3  player-selected column, 0 = leftmost.
- tiempo  in  1  one-cycle timeout pulse from the turn timer.
- posicion_ra  in  8  random value from the timer, sampled only with `tiempo`.
- gano  in  1  game won; freezes all moves while high.
- guardado  out  1  one-cycle pulse: a piece was committed.
- turno  out  1  player to move; 0 = player 1, 1 = player 2.
- tablero  out  2*ROWS*COLS  board image. Cell (r,c) is at bits [2*(r*COLS+c) +: 2]; row 0 is the bottom. Encoding: 00 empty, 01 player 1, 10 player 2.
- ultima_fila  out  3  row of the last committed piece.
- ultima_col  out  3  column of the last committed piece.
- invalida  out  1  one-cycle pulse: manual move rejected.
- tablero_lleno  out  1  level; no empty cell remains.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all cells 00.
  - guardado=0, invalida=0, turno=0, ultima_fila=0, ultima_col=0, tablero_lleno=0, busy=0.
  - Reset mid-operation aborts the move; no partial write survives.
- FSM states: IDLE, CHECK, FIND, PLACE, DONE.
- IDLE:
  - If gano=1 or tablero_lleno=1, ignore all requests.
  - btn_confirm=1 with col_sel>=COLS: pulse invalida next cycle, stay IDLE.
  - btn_confirm=1 with col_sel<COLS: latch c=col_sel, src=manual, attempts=0, go to CHECK.
  - tiempo=1 (and no btn_confirm): latch c=posicion_ra mod COLS, src=auto, attempts=0, go to CHECK.
  - btn_confirm and tiempo in the same cycle: manual wins; tiempo is dropped.
- CHECK (one column per cycle):
  - Column c is full iff cell (ROWS-1,c) != 00.
  - Not full: r=0, go to FIND.
  - Full, src=manual: pulse invalida, go to IDLE, turno unchanged.
  - Full, src=auto: c=(c+1) mod COLS (wrap COLS-1 -> 0), attempts+1, stay in CHECK.
  - If attempts reaches COLS: set tablero_lleno=1, go to IDLE, no guardado.
- FIND (one row per cycle):
  - Cell (r,c) empty: go to PLACE with that r.
  - Otherwise r=r+1.
  - r never exceeds ROWS-1, because CHECK guaranteed a free cell.
- PLACE:
  - At the closing edge, write cell (r,c) = turno ? 10 : 01, ultima_fila=r, ultima_col=c.
  - Go to DONE.
- DONE:
  - guardado=1 for exactly this cycle.
  - At the closing edge, turno toggles.
  - tablero_lleno is set if every top-row cell is now non-empty.
  - Go to IDLE.
- Latency: request sampled at edge t with k pieces already in the target column:
  - CHECK in cycle t+1, FIND t+2..t+2+k, PLACE t+3+k.
  - The board change is visible in cycle t+4+k, when guardado=1.
  - turno flips at cycle t+5+k.
- Auto with j full columns skipped adds j cycles.
- btn_confirm and tiempo arriving while busy=1 are ignored (not queued).
- gano rising mid-move does not abort the move in progress; it blocks subsequent moves.
- All outputs registered; tablero is driven directly from the cell registers.

Test Plan:
- Reset, then btn_confirm with col_sel=3 on an empty board -> guardado in cycle t+4; cell (0,3)=01; ultima=(0,3); turno becomes 1.
- Three more confirms on column 3 (alternating players) -> cells (1,3)=10, (2,3)=01, (3,3)=10; the 4th guardado arrives at t+7 (k=3); turno=0 after.
- Fill column 5 to ROWS pieces, then manual col_sel=5 -> invalida one-cycle pulse, no guardado, tablero and turno unchanged; col_sel=7 also -> invalida.
- Columns 6 and 0 full, tiempo with posicion_ra=13 (13 mod 7 = 6) -> skips 6, wraps to 0, skips it, places in column 1 at its lowest empty row; guardado once.
- btn_confirm (col 2) and tiempo (posicion_ra=4) in the same cycle -> piece lands in column 2 only, single guardado; a tiempo issued while busy is ignored.
- gano=1 then btn_confirm/tiempo -> no change, busy stays 0. Separately: full board, then tiempo -> tablero_lleno=1, no guardado. rst low mid-FIND -> all cells 00, turno=0.
